lcd_write_seq: RTL and testbench

Hardware write sequencer for the character LCD. It sits directly downstream of the output peripheral bank and consumes that bank's 32-bit LCD register word. From that word it generates HD44780-compatible bus cycles (setup, enable pulse, hold, execution wait) on the LCD pins, so software issues a command or character with a single store instead of bit-banging the enable line.

---
 rtl/lcd_write_seq_if.sv | 24 ++
 rtl/lcd_write_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_write_seq.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_seq_if.sv
// LCD sequencer bus: register word from the output bank in, HD44780 pins and status out.
interface lcd_write_seq_if;
  logic [31:0] lcd_word_i;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic        lcd_busy_o;
  logic        lcd_done_o;
  logic        lcd_ovf_o;

  modport master (
    output lcd_word_i,
    input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o,
    input  lcd_on_o, lcd_busy_o, lcd_done_o, lcd_ovf_o
  );

  modport slave (
    input  lcd_word_i,
    output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o,
    output lcd_on_o, lcd_busy_o, lcd_done_o, lcd_ovf_o
  );
endinterface

// File: rtl/lcd_write_seq.sv
// HD44780 write sequencer: turns REQ toggles in the LCD register word into setup/pulse/hold/exec cycles.
// Define LCD_INIT_SEQ_EN to add the power-on wait (PWR) and the 4-command init ROM (INIT).
module lcd_write_seq #(
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_PULSE     = 25,
  parameter int unsigned T_HOLD      = 4,
  parameter int unsigned T_EXEC      = 2500,
  parameter int unsigned T_EXEC_LONG = 100000
`ifdef LCD_INIT_SEQ_EN
  ,
  parameter int unsigned T_POWERUP   = 1000000
`endif
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  lcd_write_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
`ifdef LCD_INIT_SEQ_EN
  localparam logic [2:0] S_PWR   = 3'd5;
  localparam logic [2:0] S_INIT  = 3'd6;
`endif

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX_XFER = max2(max2(T_SETUP, T_PULSE),
                                            max2(T_HOLD, max2(T_EXEC, T_EXEC_LONG)));
`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned T_MAX = max2(T_MAX_XFER, T_POWERUP);
`else
  localparam int unsigned T_MAX = T_MAX_XFER;
`endif
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);

`ifdef LCD_INIT_SEQ_EN
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  logic       init_act_q, init_act_d;
  logic [2:0] init_idx_q, init_idx_d;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, req_q;
  logic             pend_vld_q, pend_vld_d;
  logic [8:0]       pend_q, pend_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             on_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             req_c, take, pop, cnt_zero, exec_long;
  logic [8:0]       word_c;
  logic             unused_word_bits;

  assign req_c            = armed_q && (bus.lcd_word_i[30] != req_q);
  assign word_c           = {bus.lcd_word_i[9], bus.lcd_word_i[7:0]};
  assign cnt_zero         = (cnt_q == '0);
  assign exec_long        = !rs_q && (data_q >= 8'h01) && (data_q <= 8'h03);
  assign unused_word_bits = ^{bus.lcd_word_i[29:10], bus.lcd_word_i[8]};

  // Next state, counter, pending buffer and registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    data_d     = data_q;
    rs_d       = rs_q;
    ovf_d      = ovf_q;
    take       = 1'b0;
    pop        = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_act_d = init_act_q;
    init_idx_d = init_idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) pop = 1'b1;
        else if (req_c) take = 1'b1;
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_PULSE;
          cnt_d   = CNT_W'(T_PULSE - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_EXEC;
          cnt_d   = exec_long ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      S_EXEC: begin
        if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
`ifdef LCD_INIT_SEQ_EN
        else if (init_act_q) state_d = S_INIT;
`endif
        else if (pend_vld_q) pop = 1'b1;
        else if (req_c) take = 1'b1;
        else state_d = S_IDLE;
      end
`ifdef LCD_INIT_SEQ_EN
      S_PWR: begin
        if (cnt_q == CNT_W'(T_POWERUP - 1)) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_INIT: begin
        if (init_idx_q == 3'd4) begin
          state_d    = S_IDLE;
          init_act_d = 1'b0;
        end else begin
          state_d    = S_SETUP;
          cnt_d      = CNT_W'(T_SETUP - 1);
          data_d     = init_cmd(init_idx_q[1:0]);
          rs_d       = 1'b0;
          init_idx_d = init_idx_q + 3'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (pop || take) begin
      state_d        = S_SETUP;
      cnt_d          = CNT_W'(T_SETUP - 1);
      {rs_d, data_d} = pop ? pend_q : word_c;
    end

    // A pop frees the single slot on the same edge, so a coincident request still fits
    if (pop) pend_vld_d = 1'b0;
    if (req_c && !take) begin
      if (!pend_vld_q || pop) begin
        pend_vld_d = 1'b1;
        pend_d     = word_c;
      end else ovf_d = 1'b1;
    end

    en_d   = (state_d == S_PULSE);
    done_d = (state_d == S_EXEC) && (cnt_d == '0);
    busy_d = (state_d != S_IDLE) || pend_vld_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
`ifdef LCD_INIT_SEQ_EN
      state_q    <= S_PWR;
      init_act_q <= 1'b1;
      init_idx_q <= '0;
`else
      state_q    <= S_IDLE;
`endif
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      req_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      on_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
`ifdef LCD_INIT_SEQ_EN
      init_act_q <= init_act_d;
      init_idx_q <= init_idx_d;
`endif
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= 1'b1;
      req_q      <= bus.lcd_word_i[30];
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      on_q       <= bus.lcd_word_i[31];
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.lcd_data_o = data_q;
  assign bus.lcd_rs_o   = rs_q;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_en_o   = en_q;
  assign bus.lcd_on_o   = on_q;
  assign bus.lcd_busy_o = busy_q;
  assign bus.lcd_done_o = done_q;
  assign bus.lcd_ovf_o  = ovf_q;

endmodule

// File: tb/tb_lcd_write_seq.sv
// Bench for lcd_write_seq: directed timing table, hand sequences, and random traffic against a timeline model.
module tb_lcd_write_seq;
  localparam int S = 2;
  localparam int P = 3;
  localparam int H = 2;
  localparam int E = 5;
  localparam int L = 20;
`ifdef LCD_INIT_SEQ_EN
  localparam int PW = 10;
`endif

  logic        clk;
  logic        rst_ni;
  logic [31:0] word;

  lcd_write_seq_if bus();
  assign bus.lcd_word_i = word;

  lcd_write_seq #(
    .T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_EXEC(E), .T_EXEC_LONG(L)
`ifdef LCD_INIT_SEQ_EN
    , .T_POWERUP(PW)
`endif
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer timeline: accepted at edge a, SETUP at edge s, EXEC exit at edge x
  typedef struct {
    int         a;
    int         s;
    int         x;
    logic       rs;
    logic [7:0] d;
    logic       usr;
  } xfer_t;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         done_off;
  } vec_t;

  xfer_t      tq[$];
  int         t, init_end;
  logic       armed_m, req_m, on_m, ovf_m;
  int         checks, errors;
  int         rise_t, fall_t, done_t;
  logic [7:0] rise_d;
  logic       rise_rs, en_prev;
  logic [7:0] rises[$];
  int         rise_ts[$];
  int         dones[$];

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? L : E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h want %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    tq.delete();
    t = 0; init_end = 0;
    armed_m = 1'b0; req_m = 1'b0; on_m = 1'b0; ovf_m = 1'b0; en_prev = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    begin
      logic [7:0] rom_m [4];
      int s, x;
      rom_m = '{8'h38, 8'h0C, 8'h01, 8'h06};
      s = PW + 1;
      for (int i = 0; i < 4; i++) begin
        x = s + S + P + H + exec_len(1'b0, rom_m[i]);
        tq.push_back('{a: s, s: s, x: x, rs: 1'b0, d: rom_m[i], usr: 1'b0});
        s = x + 1;
      end
      init_end = s - 1;
    end
`endif
  endtask

  task automatic model_request(input int k, input logic rs, input logic [7:0] d);
    int n, last_x, s;
    n = 0; last_x = 0;
    if (k <= init_end) begin
      foreach (tq[i]) if (tq[i].usr) n++;
      if (n >= 1) ovf_m = 1'b1;
      else begin
        s = init_end + 1;
        tq.push_back('{a: k, s: s, x: s + S + P + H + exec_len(rs, d), rs: rs, d: d, usr: 1'b1});
      end
    end else begin
      foreach (tq[i]) if (tq[i].x > k) begin
        n++;
        if (tq[i].x > last_x) last_x = tq[i].x;
      end
      if (n >= 2) ovf_m = 1'b1;
      else begin
        s = (n == 0) ? k : last_x;
        tq.push_back('{a: k, s: s, x: s + S + P + H + exec_len(rs, d), rs: rs, d: d, usr: 1'b1});
      end
    end
  endtask

  task automatic check_all();
    logic       en_e, done_e, busy_e, rs_e;
    logic [7:0] d_e;
    int         best;
    en_e = 1'b0; done_e = 1'b0; rs_e = 1'b0; d_e = 8'h00; best = -1;
    busy_e = (t >= 1 && t < init_end);
    foreach (tq[i]) begin
      if (tq[i].s + S <= t && t < tq[i].s + S + P) en_e = 1'b1;
      if (tq[i].x - 1 == t) done_e = 1'b1;
      if (tq[i].a <= t && t < tq[i].x) busy_e = 1'b1;
      if (tq[i].s <= t && tq[i].s > best) begin
        best = tq[i].s; d_e = tq[i].d; rs_e = tq[i].rs;
      end
    end
    chk("en",   32'(bus.lcd_en_o),   32'(en_e));
    chk("done", 32'(bus.lcd_done_o), 32'(done_e));
    chk("busy", 32'(bus.lcd_busy_o), 32'(busy_e));
    chk("ovf",  32'(bus.lcd_ovf_o),  32'(ovf_m));
    chk("on",   32'(bus.lcd_on_o),   32'(on_m));
    chk("rw",   32'(bus.lcd_rw_o),   32'd0);
    chk("data", 32'(bus.lcd_data_o), 32'(d_e));
    chk("rs",   32'(bus.lcd_rs_o),   32'(rs_e));
  endtask

  task automatic track();
    if (bus.lcd_en_o && !en_prev) begin
      rise_t = t; rise_d = bus.lcd_data_o; rise_rs = bus.lcd_rs_o;
      rises.push_back(bus.lcd_data_o); rise_ts.push_back(t);
    end
    if (!bus.lcd_en_o && en_prev) fall_t = t;
    if (bus.lcd_done_o) begin
      done_t = t; dones.push_back(t);
    end
    en_prev = bus.lcd_en_o;
  endtask

  task automatic step();
    logic req;
    @(posedge clk);
    t++;
    req = armed_m && (word[30] != req_m);
    armed_m = 1'b1; req_m = word[30]; on_m = word[31];
    if (req) model_request(t, word[9], word[7:0]);
    #1;
    check_all();
    track();
  endtask

  task automatic toggle(input logic rs, input logic [7:0] d);
    word[30] = ~word[30]; word[9] = rs; word[7:0] = d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.lcd_busy_o === 1'b1 && n < 500) begin step(); n++; end
    chk("wait_idle", 32'(bus.lcd_busy_o), 32'd0);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (bus.lcd_en_o !== 1'b1 && n < 40) begin step(); n++; end
    chk("wait_en", 32'(bus.lcd_en_o), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   k, n, base;

    vecs[0] = '{1'b1, 8'h41, 11};
    vecs[1] = '{1'b0, 8'h01, 26};
    vecs[2] = '{1'b0, 8'h02, 26};
    vecs[3] = '{1'b0, 8'h03, 26};
    vecs[4] = '{1'b0, 8'h04, 11};
    vecs[5] = '{1'b1, 8'h02, 11};
    vecs[6] = '{1'b0, 8'h00, 11};
    vecs[7] = '{1'b1, 8'h01, 11};

    checks = 0; errors = 0;
    rise_t = -1; fall_t = -1; done_t = -1; rise_d = '0; rise_rs = 1'b0;
    word = 32'hC000_0000;
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en",   32'(bus.lcd_en_o),   32'd0);
    chk("rst_busy", 32'(bus.lcd_busy_o), 32'd0);
    chk("rst_done", 32'(bus.lcd_done_o), 32'd0);
    chk("rst_ovf",  32'(bus.lcd_ovf_o),  32'd0);
    chk("rst_on",   32'(bus.lcd_on_o),   32'd0);
    chk("rst_data", 32'(bus.lcd_data_o), 32'd0);
    chk("rst_rs",   32'(bus.lcd_rs_o),   32'd0);
    rst_ni = 1'b1;

    // Arm edge with REQ already 1 must not start anything
    step();
    wait_idle();
`ifdef LCD_INIT_SEQ_EN
    chk("init_cnt", 32'(rises.size()), 32'd4);
    if (rises.size() == 4) begin
      chk("init0", 32'(rises[0]), 32'h38);
      chk("init1", 32'(rises[1]), 32'h0C);
      chk("init2", 32'(rises[2]), 32'h01);
      chk("init3", 32'(rises[3]), 32'h06);
    end
`else
    chk("arm_no_xfer", 32'(rises.size()), 32'd0);
`endif

    // Directed timing table
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      done_t = -1; rise_t = -1; fall_t = -1;
      toggle(vecs[i].rs, vecs[i].d);
      step(); k = t;
      n = 0;
      while (done_t < 0 && n < 60) begin step(); n++; end
      chk("en_rise_off",  32'(rise_t - k),      32'(S));
      chk("en_width",     32'(fall_t - rise_t), 32'(P));
      chk("done_off",     32'(done_t - k),      32'(vecs[i].done_off));
      chk("data_at_en",   32'(rise_d),          32'(vecs[i].d));
      chk("rs_at_en",     32'(rise_rs),         32'(vecs[i].rs));
    end

    // Queued request then overflow
    wait_idle();
    rises.delete(); rise_ts.delete(); dones.delete();
    toggle(1'b1, 8'h41); step();
    wait_en();
    toggle(1'b1, 8'h42); step();
    chk("q_ovf0", 32'(bus.lcd_ovf_o), 32'd0);
    step();
    toggle(1'b1, 8'h43); step();
    chk("q_ovf1", 32'(bus.lcd_ovf_o), 32'd1);
    wait_idle();
    chk("q_cnt", 32'(rises.size()), 32'd2);
    if (rises.size() == 2 && dones.size() >= 1) begin
      chk("q_d0", 32'(rises[0]), 32'h41);
      chk("q_d1", 32'(rises[1]), 32'h42);
      chk("q_b2b", 32'(rise_ts[1] - dones[0]), 32'(S + 1));
    end

    // Power bit mid-transfer
    done_t = -1;
    toggle(1'b1, 8'h50); step(); k = t;
    step(); step();
    word[31] = 1'b0;
    step();
    chk("pwr_off", 32'(bus.lcd_on_o), 32'd0);
    n = 0;
    while (done_t < 0 && n < 60) begin step(); n++; end
    chk("pwr_done_off", 32'(done_t - k), 32'd11);
    word[31] = 1'b1;

    // Reset while EN is high
    wait_idle();
    word[30] = 1'b0; step();
    toggle(1'b1, 8'h41); step();
    wait_en();
    #2 rst_ni = 1'b0;
    #1;
    chk("rr_en",   32'(bus.lcd_en_o),   32'd0);
    chk("rr_busy", 32'(bus.lcd_busy_o), 32'd0);
    chk("rr_done", 32'(bus.lcd_done_o), 32'd0);
    chk("rr_ovf",  32'(bus.lcd_ovf_o),  32'd0);
    word[30] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    base = rises.size();
    repeat (20) step();
    wait_idle();
`ifdef LCD_INIT_SEQ_EN
    chk("rr_no_xfer", 32'(rises.size() - base), 32'd4);
`else
    chk("rr_no_xfer", 32'(rises.size() - base), 32'd0);
`endif

    // Random traffic against the timeline model
    for (int i = 0; i < 600; i++) begin
      word[29:10] = 20'($urandom);
      word[8]     = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 2) == 0) toggle(1'($urandom), 8'($urandom_range(1, 3)));
        else toggle(1'($urandom), 8'($urandom));
      end
      if ($urandom_range(0, 15) == 0) word[31] = ~word[31];
      step();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
